pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Generates per-stage enables and flush/bubble controls for load-use hazards, taken branches and multi-cycle data-memory accesses. Produces forwarding selects for the EX operand muxes from the EX/MEM and MEM/WB Rd tags. Keeps saturating stall/flush performance counters and flags a data-memory timeout.

Parameters:
MEM_TIMEOUT, 16, MEM_WAIT cycles tolerated before ERROR (range 1..255)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  pipeline clock, rising edge
reset_n  in  1  asynchronous, active-low reset
ID_Rs1, ID_Rs2  in  5 each  source regs of the instruction in decode
EX_Rs1, EX_Rs2  in  5 each  source regs of the instruction in execute
EX_Rd  in  5  dest reg in execute
EX_mem_read  in  1  execute-stage instruction is a load
MEM_Rd, WB_Rd  in  5 each  dest regs held in EX/MEM and MEM/WB
MEM_reg_write, WB_reg_write  in  1 each  those stages write the register file
branch_taken  in  1  EX resolved a taken branch/jump this cycle
dmem_req  in  1  MEM stage is accessing data memory
dmem_ready  in  1  data memory completes the access this cycle
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register load enables
if_id_flush, id_ex_flush, mem_wb_bubble  out  1 each  load a NOP/bubble instead of data
forward_a, forward_b  out  2 each  00 regfile, 10 from EX/MEM, 01 from MEM/WB
mem_err  out  1  sticky data-memory timeout flag
stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- State register: RUN, MEM_WAIT, ERROR; wait_cnt is 8 bits. reset_n low (async): state=RUN, wait_cnt=0, mem_err=0, counters=0. While reset_n is low, all enables, flushes, bubble and forward selects are forced to 0.
- Control outputs are combinational from state and inputs. Zero added latency: a hazard is resolved in the same cycle it is detected.
- Priority within RUN: memory stall > branch flush > load-use stall.
- RUN, dmem_req=1 and dmem_ready=0:
  - pc/if_id/id_ex/ex_mem enables=0; mem_wb_en=1 with mem_wb_bubble=1.
  - Next state MEM_WAIT, wait_cnt<=1.
  - branch_taken and load-use are ignored this cycle. The flush happens once the stall is released, because EX holds.
- MEM_WAIT, dmem_ready=0: same outputs as the RUN stall case.
  - If wait_cnt==MEM_TIMEOUT: go to ERROR and set mem_err.
  - Otherwise wait_cnt++.
  - An access therefore fails after MEM_TIMEOUT+1 consecutive not-ready cycles.
- MEM_WAIT, dmem_ready=1: all enables=1, no bubble; back to RUN, wait_cnt<=0. Branch/load-use rules apply in this cycle exactly as in RUN.
- RUN, branch_taken=1 (no memory stall): all enables=1, if_id_flush=1, id_ex_flush=1.
- RUN, load-use (EX_mem_read and EX_Rd!=0 and EX_Rd equals ID_Rs1 or ID_Rs2), no branch:
  - pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1.
  - ex_mem_en=1, mem_wb_en=1.
- RUN, no hazard: all enables=1, no flush/bubble.
- ERROR: all enables=0, flushes=0, mem_err=1. The block stays in ERROR until reset_n is asserted.
- Forwarding (independent of state, also valid during stalls):
  - forward_a=10 if MEM_reg_write and MEM_Rd!=0 and MEM_Rd==EX_Rs1.
  - Otherwise forward_a=01 if WB_reg_write and WB_Rd!=0 and WB_Rd==EX_Rs1.
  - Otherwise forward_a=00. forward_b uses the same rules with EX_Rs2.
  - EX/MEM wins when both stages match.
- stall_cnt increments on every cycle outside ERROR with pc_en=0. flush_cnt increments on every cycle with if_id_flush=1. Both saturate at all-ones and do not wrap.

Test Plan:
- Reset mid-operation: stall in MEM_WAIT with wait_cnt=5, drop reset_n asynchronously -> outputs 0 immediately; after release: state RUN, mem_err=0, counters 0, all enables 1 when idle.
- Load-use: EX_mem_read=1, EX_Rd=5, ID_Rs2=5 -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly one cycle, stall_cnt +1. Repeat with EX_Rd=0 -> no stall.
- Branch during load-use: branch_taken=1 and load-use true together -> if_id_flush=id_ex_flush=1, pc_en=1, flush_cnt +1, stall_cnt unchanged.
- Memory wait: dmem_req=1, dmem_ready low 3 cycles then high -> 3 stall cycles with mem_wb_bubble=1, all enables 1 on the 4th cycle, stall_cnt=3.
- Timeout: MEM_TIMEOUT=16, dmem_ready held 0 -> ERROR after 17 not-ready cycles; mem_err=1 and all enables 0 thereafter, including when dmem_ready later rises.
- Forwarding: EX_Rs1=7, MEM_Rd=7, WB_Rd=7, both reg_write=1 -> forward_a=10; clear MEM_reg_write -> 01; set Rd=0 -> 00.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables, flush/bubble for load-use,
// taken branches and data-memory waits, EX forwarding selects and perf counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic [4:0]       EX_Rs1,
  input  logic [4:0]       EX_Rs2,
  input  logic [4:0]       EX_Rd,
  input  logic             EX_mem_read,
  input  logic [4:0]       MEM_Rd,
  input  logic [4:0]       WB_Rd,
  input  logic             MEM_reg_write,
  input  logic             WB_reg_write,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             mem_stall, halted, load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic mem_w, input logic [4:0] mem_rd,
                                         input logic wb_w, input logic [4:0] wb_rd);
    if (mem_w && mem_rd != 5'd0 && mem_rd == rs)  return 2'b10;
    else if (wb_w && wb_rd != 5'd0 && wb_rd == rs) return 2'b01;
    else return 2'b00;
  endfunction

  assign load_use = EX_mem_read && (EX_Rd != 5'd0) && (EX_Rd == ID_Rs1 || EX_Rd == ID_Rs2);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    err_d     = err_q;
    mem_stall = 1'b0;
    halted    = 1'b0;
    case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          mem_stall = 1'b1;
          state_d   = MEM_WAIT;
          wait_d    = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          mem_stall = 1'b1;
          if (wait_q == 8'(MEM_TIMEOUT)) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end else begin
          state_d = RUN;
          wait_d  = 8'd0;
        end
      end
      ERROR: begin
        halted = 1'b1;
        err_d  = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Hazard priority: halt > memory stall > branch flush > load-use stall.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    forward_a     = fwd_sel(EX_Rs1, MEM_reg_write, MEM_Rd, WB_reg_write, WB_Rd);
    forward_b     = fwd_sel(EX_Rs2, MEM_reg_write, MEM_Rd, WB_reg_write, WB_Rd);
    if (halted) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
    end else if (mem_stall) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
      mem_wb_bubble = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
    if (!reset_n) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      {if_id_flush, id_ex_flush, mem_wb_bubble}         = 3'b000;
      forward_a = 2'b00;
      forward_b = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (!halted && !pc_en && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (if_id_flush && flush_q != '1)      flush_q <= flush_q + 1'b1;
    end
  end

  assign mem_err   = err_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
